// File: rtl/stage_cmd_dispatch_if.sv
// Signal bundle between a command source / EKF core and stage_cmd_dispatch.
// master: the side offering commands and reporting core status.
// slave:  the dispatcher itself.
interface stage_cmd_dispatch_if #(
    parameter int unsigned CNT_W = 3
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_stage;
    logic signed [31:0] cmd_op0;
    logic signed [31:0] cmd_op1;
    logic [2:0]         stage_val;
    logic               stage_rdy;
    logic signed [31:0] vlr;
    logic signed [31:0] alpha;
    logic signed [31:0] rk;
    logic signed [31:0] phi;
    logic               done_pulse;
    logic [2:0]         done_stage;
    logic               err_illegal;
    logic               err_tmo;
    logic               busy;
    logic [CNT_W-1:0]   fifo_cnt;

    modport master (
        output cmd_valid, cmd_stage, cmd_op0, cmd_op1, stage_rdy,
        input  cmd_ready, stage_val, vlr, alpha, rk, phi,
               done_pulse, done_stage, err_illegal, err_tmo, busy, fifo_cnt
    );

    modport slave (
        input  cmd_valid, cmd_stage, cmd_op0, cmd_op1, stage_rdy,
        output cmd_ready, stage_val, vlr, alpha, rk, phi,
               done_pulse, done_stage, err_illegal, err_tmo, busy, fifo_cnt
    );
endinterface

// File: rtl/stage_cmd_dispatch.sv
// Queues stage commands from the PS and sequences them one at a time to the
// EKF core: operands are loaded, the stage code is raised until the core has
// gone busy and finished (or a timeout expires), then a completion strobe.
module stage_cmd_dispatch #(
    parameter int unsigned      FIFO_DEPTH = 4,
    parameter int unsigned      TMO_W      = 16,
    parameter logic [TMO_W-1:0] TMO_CYC    = 16'd4095
) (
    input logic                 clk,
    input logic                 sys_rst,
    stage_cmd_dispatch_if.slave bus
);
    localparam int unsigned      PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned      CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_RELEASE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [66:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             ready;
    logic             push;
    logic             pop;
    logic [2:0]       head_stage;
    logic [31:0]      head_op0;
    logic [31:0]      head_op1;
    logic             head_legal;
    logic [2:0]       code_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             abort_nxt;
    logic             abort_q;
    logic [2:0]       stage_val;
    logic [31:0]      vlr_q;
    logic [31:0]      alpha_q;
    logic [31:0]      rk_q;
    logic [31:0]      phi_q;
    logic [2:0]       done_stage_q;
    logic             err_illegal_q;

    // Handshake and head-of-queue decode; pop only from IDLE with a non-empty FIFO
    always_comb begin
        ready = (cnt != FULL_CNT);
        push  = bus.cmd_valid && ready;
        pop   = (state == S_IDLE) && (cnt != '0);
        {head_stage, head_op0, head_op1} = fifo_mem[rd_ptr];
        head_legal = (head_stage >= 3'd1) && (head_stage <= 3'd4);
    end

    // Command storage
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.cmd_stage, bus.cmd_op0, bus.cmd_op1};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Next-state and stage request decode
    always_comb begin
        state_nxt = state;
        stage_val = '0;
        abort_nxt = 1'b0;
        tmo_hit   = (tmo_cnt == TMO_CYC - 1'b1);
        case (state)
            S_IDLE: begin
                if (pop && head_legal) begin
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                stage_val = code_q;
                if (tmo_hit) begin
                    state_nxt = S_RELEASE;
                    abort_nxt = 1'b1;
                end else if (!bus.stage_rdy) begin
                    state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                stage_val = code_q;
                // A finish seen on the last allowed cycle still counts as done
                if (bus.stage_rdy) begin
                    state_nxt = S_RELEASE;
                end else if (tmo_hit) begin
                    state_nxt = S_RELEASE;
                    abort_nxt = 1'b1;
                end
            end
            S_RELEASE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register, timeout counter and completion status
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= S_IDLE;
            tmo_cnt      <= '0;
            abort_q      <= 1'b0;
            done_stage_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_SETUP) begin
                tmo_cnt <= '0;
            end else if ((state == S_WAIT_ACK) || (state == S_WAIT_DONE)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (((state == S_WAIT_ACK) || (state == S_WAIT_DONE)) && (state_nxt == S_RELEASE)) begin
                abort_q      <= abort_nxt;
                done_stage_q <= code_q;
            end
        end
    end

    // Operand and code capture at the pop, illegal-code strobe
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            code_q        <= '0;
            vlr_q         <= '0;
            alpha_q       <= '0;
            rk_q          <= '0;
            phi_q         <= '0;
            err_illegal_q <= 1'b0;
        end else begin
            err_illegal_q <= pop && !head_legal;
            if (pop && head_legal) begin
                code_q <= head_stage;
                if (head_stage == 3'd1) begin
                    vlr_q   <= head_op0;
                    alpha_q <= head_op1;
                end else begin
                    rk_q    <= head_op0;
                    phi_q   <= head_op1;
                end
            end
        end
    end

    assign bus.cmd_ready   = ready;
    assign bus.stage_val   = stage_val;
    assign bus.vlr         = vlr_q;
    assign bus.alpha       = alpha_q;
    assign bus.rk          = rk_q;
    assign bus.phi         = phi_q;
    assign bus.done_pulse  = (state == S_RELEASE) && !abort_q;
    assign bus.err_tmo     = (state == S_RELEASE) && abort_q;
    assign bus.done_stage  = done_stage_q;
    assign bus.err_illegal = err_illegal_q;
    assign bus.busy        = (state != S_IDLE);
    assign bus.fifo_cnt    = cnt;
endmodule

// File: tb/tb_stage_cmd_dispatch.sv
// Scoreboard bench for stage_cmd_dispatch: stimulus pushes the events each
// accepted command must produce; a negedge monitor pops them as the DUT
// shows a stage request, a completion or an illegal-code strobe.
module tb_stage_cmd_dispatch;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 8;

    typedef enum int {EV_ISSUE, EV_DONE, EV_TMO, EV_ILL} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [2:0]  code;
        logic [31:0] vlr;
        logic [31:0] alpha;
        logic [31:0] rk;
        logic [31:0] phi;
        int unsigned dur;
    } ev_t;

    logic        clk = 1'b0;
    logic        sys_rst;
    int unsigned tests = 0;
    int unsigned fails = 0;
    ev_t         exp_q[$];
    int unsigned core_a[$];
    int unsigned core_b[$];
    logic [31:0] m_vlr, m_alpha, m_rk, m_phi;

    ev_t         got;
    logic        got_ok;
    ev_t         cur;
    logic        act_on = 1'b0;
    int unsigned act_len = 0;
    int unsigned gap = 2;

    logic        core_on = 1'b0;
    int unsigned core_k = 0;
    int unsigned ca = 0;
    int unsigned cb = 1;

    stage_cmd_dispatch_if #(.CNT_W(3)) bus ();

    stage_cmd_dispatch #(
        .FIFO_DEPTH(DEPTH),
        .TMO_W     (16),
        .TMO_CYC   (16'd8)
    ) dut (
        .clk    (clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic take(input ev_kind_t kind, input string name);
        tests++;
        got_ok = 1'b0;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: got event %s, expected no event", name, kind.name());
        end else begin
            got = exp_q.pop_front();
            if (got.kind != kind) begin
                fails++;
                $display("FAIL %s: got event %s, expected %s", name, kind.name(), got.kind.name());
            end else begin
                got_ok = 1'b1;
            end
        end
    endtask

    // Reference: legal commands are served strictly in acceptance order. A PRD
    // replaces vlr/alpha, any other legal code replaces rk/phi. The core model
    // stays ready for a request cycles, busy for b, then ready again, so the
    // stage completes at request cycle a+b if that lies inside the TMO window.
    task automatic model_accept(input logic [2:0] st, input logic [31:0] o0, input logic [31:0] o1,
                                input int unsigned a, input int unsigned b);
        ev_t ev;
        if (st >= 3'd1 && st <= 3'd4) begin
            if (st == 3'd1) begin
                m_vlr = o0; m_alpha = o1;
            end else begin
                m_rk = o0; m_phi = o1;
            end
            ev.kind = EV_ISSUE; ev.code = st; ev.dur = 0;
            ev.vlr = m_vlr; ev.alpha = m_alpha; ev.rk = m_rk; ev.phi = m_phi;
            exp_q.push_back(ev);
            if (a + b < TMO) begin
                ev.kind = EV_DONE; ev.dur = a + b + 1;
            end else begin
                ev.kind = EV_TMO; ev.dur = TMO;
            end
            exp_q.push_back(ev);
            core_a.push_back(a);
            core_b.push_back(b);
        end else begin
            ev.kind = EV_ILL; ev.code = st; ev.dur = 0;
            ev.vlr = m_vlr; ev.alpha = m_alpha; ev.rk = m_rk; ev.phi = m_phi;
            exp_q.push_back(ev);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [2:0] st, input logic [31:0] o0, input logic [31:0] o1,
                        input int unsigned a, input int unsigned b);
        int unsigned w = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_stage = st;
        bus.cmd_op0   = o0;
        bus.cmd_op1   = o1;
        while (!bus.cmd_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!bus.cmd_ready) begin
            tests++;
            fails++;
            $display("FAIL send_wait: got cmd_ready=0 after %0d cycles, expected 1", w);
            bus.cmd_valid = 1'b0;
            return;
        end
        model_accept(st, o0, o1, a, b);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned w = 0;
        while ((exp_q.size() != 0 || bus.busy || bus.fifo_cnt != 3'd0) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check("drain_events", 32'(exp_q.size()), 32'd0);
        check("drain_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_active();
        int unsigned w = 0;
        while (bus.stage_val == 3'd0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("wait_active", 32'(bus.stage_val != 3'd0), 32'd1);
    endtask

    task automatic wait_strobe();
        int unsigned w = 0;
        while (!(bus.done_pulse || bus.err_tmo) && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("wait_strobe", 32'(bus.done_pulse || bus.err_tmo), 32'd1);
    endtask

    // EKF core model: drives stage_rdy per request cycle from the (a,b) of the command
    always @(negedge clk) begin
        if (sys_rst || bus.stage_val == 3'd0) begin
            core_on = 1'b0;
            core_k  = 0;
            bus.stage_rdy = 1'b1;
        end else begin
            if (!core_on) begin
                core_on = 1'b1;
                core_k  = 0;
                if (core_a.size() != 0) begin
                    ca = core_a.pop_front();
                    cb = core_b.pop_front();
                end else begin
                    ca = 0;
                    cb = 1;
                end
            end
            bus.stage_rdy = !(core_k >= ca && core_k < ca + cb);
            core_k++;
        end
    end

    // Monitor: compares every DUT event against the scoreboard
    always @(negedge clk) begin
        if (sys_rst) begin
            act_on  = 1'b0;
            act_len = 0;
            gap     = 2;
        end else begin
            check("cmd_ready_rule", 32'(bus.cmd_ready), 32'(bus.fifo_cnt != 3'd4));
            if (bus.stage_val != 3'd0) begin
                if (!act_on) begin
                    check("stage_gap", 32'(gap >= 2), 32'd1);
                    take(EV_ISSUE, "issue");
                    cur     = got;
                    act_on  = 1'b1;
                    act_len = 0;
                end
                check("stage_val", 32'(bus.stage_val), 32'(cur.code));
                check("vlr", bus.vlr, cur.vlr);
                check("alpha", bus.alpha, cur.alpha);
                check("rk", bus.rk, cur.rk);
                check("phi", bus.phi, cur.phi);
                act_len++;
                gap = 0;
            end else begin
                act_on = 1'b0;
                if (gap < 100) gap++;
            end
            if (bus.done_pulse || bus.err_tmo) begin
                check("one_strobe", 32'(bus.done_pulse && bus.err_tmo), 32'd0);
                take(bus.err_tmo ? EV_TMO : EV_DONE, "completion");
                if (got_ok) begin
                    check("done_stage", 32'(bus.done_stage), 32'(got.code));
                    check("stage_cycles", act_len, got.dur);
                end
            end
            if (bus.err_illegal) begin
                take(EV_ILL, "illegal");
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000, expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        int unsigned r;
        logic [2:0]  st;
        sys_rst       = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_stage = 3'd0;
        bus.cmd_op0   = '0;
        bus.cmd_op1   = '0;
        m_vlr = '0; m_alpha = '0; m_rk = '0; m_phi = '0;
        repeat (3) @(negedge clk);
        check("rst_stage_val", 32'(bus.stage_val), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_fifo_cnt", 32'(bus.fifo_cnt), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_strobes", 32'({bus.done_pulse, bus.err_illegal, bus.err_tmo}), 32'd0);
        check("rst_done_stage", 32'(bus.done_stage), 32'd0);
        check("rst_operands", bus.vlr | bus.alpha | bus.rk | bus.phi, 32'd0);
        sys_rst = 1'b0;
        @(negedge clk);

        // PRD with known operands; pop cycle N, request visible at N+2
        send(3'd1, 32'h0001_0000, 32'h0000_4000, 0, 3);
        n = 1;
        while (bus.stage_val == 3'd0 && n < 20) begin
            if (n == 2) check("setup_vlr", bus.vlr, 32'h0001_0000);
            @(negedge clk);
            n++;
        end
        check("issue_latency", n, 32'd3);
        wait_idle();

        // Illegal code followed by UPD
        send(3'd6, 32'h1234_5678, 32'h9abc_def0, 0, 1);
        send(3'd3, 32'hffff_fff0, 32'h0000_0123, 1, 2);
        wait_idle();

        // stage_rdy never drops: abort after TMO request cycles
        send(3'd2, 32'h0000_0042, 32'h8000_0000, 20, 1);
        wait_idle();

        // Fill while the core is stalled; fifth command held
        send(3'd1, 32'h0000_0011, 32'h0000_0022, 0, 30);
        wait_active();
        for (int i = 0; i < 4; i++) begin
            send(3'(1 + i), $urandom, $urandom, 1, 2);
        end
        check("full_cnt", 32'(bus.fifo_cnt), 32'd4);
        check("full_ready", 32'(bus.cmd_ready), 32'd0);
        send(3'd4, $urandom, $urandom, 0, 1);
        wait_idle();

        // Push and pop in the same cycle at occupancy 2
        send(3'd3, $urandom, $urandom, 0, 6);
        wait_active();
        send(3'd1, $urandom, $urandom, 1, 1);
        send(3'd2, $urandom, $urandom, 0, 2);
        wait_strobe();
        @(negedge clk);
        check("pre_pushpop_cnt", 32'(bus.fifo_cnt), 32'd2);
        send(3'd4, $urandom, $urandom, 2, 1);
        check("pushpop_cnt", 32'(bus.fifo_cnt), 32'd2);
        wait_idle();

        // Reset in WAIT_DONE with two commands queued
        send(3'd2, $urandom, $urandom, 0, 40);
        wait_active();
        send(3'd1, $urandom, $urandom, 0, 1);
        send(3'd4, $urandom, $urandom, 0, 1);
        @(negedge clk);
        #2 sys_rst = 1'b1;
        exp_q.delete();
        core_a.delete();
        core_b.delete();
        m_vlr = '0; m_alpha = '0; m_rk = '0; m_phi = '0;
        #1;
        check("arst_stage_val", 32'(bus.stage_val), 32'd0);
        check("arst_fifo_cnt", 32'(bus.fifo_cnt), 32'd0);
        check("arst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_strobes", 32'({bus.done_pulse, bus.err_illegal, bus.err_tmo}), 32'd0);
        check("arst_done_stage", 32'(bus.done_stage), 32'd0);
        check("arst_operands", bus.vlr | bus.alpha | bus.rk | bus.phi, 32'd0);
        @(negedge clk);
        @(negedge clk);
        sys_rst = 1'b0;
        check("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
        send(3'd4, $urandom, $urandom, 2, 2);
        wait_idle();

        // Random traffic with gaps, illegal codes and timeouts
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            r = $urandom_range(0, 9);
            if (r < 8) st = 3'(1 + r % 4);
            else if (r == 8) st = 3'd0;
            else st = 3'($urandom_range(5, 7));
            send(st, $urandom, $urandom, $urandom_range(0, 9), $urandom_range(1, 8));
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
